// File: rtl/spi_regfile_pkg.sv
// spi_regfile_pkg
// Shared definitions for the SPI register-file peripheral: the R/W bit
// encoding, the minimum m_clk:SCLK ratio the sampling scheme relies on,
// the frame-length helper and the frame-phase state type.
package spi_regfile_pkg;

  localparam logic RW_BIT_WRITE  = 1'b1;
  // Edge detection runs on synchronised copies of SCLK, so m_clk must see
  // each SCLK half-period for several cycles.
  localparam int   MIN_CLK_RATIO = 8;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    WDATA,
    RDATA
  } phase_e;

  function automatic int frame_w(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/spi_regfile_periph_sync_chain.sv
// sync_chain
// Multi-flop synchroniser for WIDTH independent asynchronous inputs.
// Ports:
//   clk    in  sampling clock
//   rst_n  in  synchronous active-low reset; loads RST_VAL into every stage
//   d      in  WIDTH  asynchronous inputs
//   q      out WIDTH  synchronised outputs (STAGES cycles of latency)
module sync_chain #(
  parameter int               WIDTH   = 1,
  parameter int               STAGES  = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [STAGES];
  logic [WIDTH-1:0] stage_d [STAGES];

  always_comb begin
    stage_d[0] = d;
    for (int i = 1; i < STAGES; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= RST_VAL;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/spi_regfile_periph.sv
// spi_regfile_periph
// SPI mode-0 peripheral giving a host write and read access to NUM_REGS
// registers of DATA_W bits. Frame: R/W bit (1 = write), ADDR_W address
// bits, DATA_W data bits, MSB first. All logic runs on m_clk; SPI pins are
// synchronised internally.
// Ports:
//   m_clk      in   system clock (>= 8x SCLK)
//   rst_n      in   synchronous active-low reset
//   sclk       in   SPI clock (asynchronous)
//   copi       in   controller-out data (asynchronous)
//   cs_n       in   chip select, active-low (asynchronous)
//   cipo       out  controller-in data
//   cipo_oe    out  pad output enable for cipo
//   regs       out  register bank, reg k at [k*DATA_W +: DATA_W]
//   wr_stb     out  one-cycle pulse when a write commits
//   wr_addr    out  address of the last committed write
//   frame_err  out  one-cycle pulse when a malformed frame ends
module spi_regfile_periph
  import spi_regfile_pkg::*;
#(
  parameter int NUM_REGS    = 5,
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       m_clk,
  input  logic                       rst_n,
  input  logic                       sclk,
  input  logic                       copi,
  input  logic                       cs_n,
  output logic                       cipo,
  output logic                       cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0] regs,
  output logic                       wr_stb,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       frame_err
);

  localparam int FRAME_W = frame_w(ADDR_W, DATA_W);
  localparam int HDR_W   = 1 + ADDR_W;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam int FILL_W  = $clog2(SYNC_STAGES + 1);

  localparam logic [CNT_W-1:0]  CNT_FRAME = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0]  CNT_HDR   = CNT_W'(HDR_W);
  localparam logic [FILL_W-1:0] FILL_DONE = FILL_W'(SYNC_STAGES);

  // Idle pattern {sclk, cs_n, copi} = {0, 1, 0}
  logic [2:0] pins_s;
  logic       sclk_s, cs_n_s, copi_s;

  sync_chain #(
    .WIDTH  (3),
    .STAGES (SYNC_STAGES),
    .RST_VAL(3'b010)
  ) u_sync (
    .clk  (m_clk),
    .rst_n(rst_n),
    .d    ({sclk, cs_n, copi}),
    .q    (pins_s)
  );

  assign {sclk_s, cs_n_s, copi_s} = pins_s;

  logic                       sclk_dly_q, sclk_dly_d;
  logic                       cs_n_dly_q, cs_n_dly_d;
  phase_e                     phase_q, phase_d;
  logic [CNT_W-1:0]           bit_cnt_q, bit_cnt_d;
  logic [FRAME_W-1:0]         shreg_q, shreg_d;
  logic                       overrun_q, overrun_d;
  logic [DATA_W-1:0]          out_sh_q, out_sh_d;
  logic [FILL_W-1:0]          fill_q, fill_d;
  logic                       armed_q, armed_d;
  logic [NUM_REGS*DATA_W-1:0] regs_q, regs_d;
  logic                       wr_stb_q, wr_stb_d;
  logic [ADDR_W-1:0]          wr_addr_q, wr_addr_d;
  logic                       frame_err_q, frame_err_d;
  logic                       cipo_q, cipo_d;
  logic                       cipo_oe_q, cipo_oe_d;

  logic              sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic              rx_rw;
  logic [ADDR_W-1:0] rx_addr, hdr_addr;
  logic [DATA_W-1:0] rx_data;

  assign sclk_rise = sclk_s & ~sclk_dly_q;
  assign sclk_fall = ~sclk_s & sclk_dly_q;
  assign cs_fall   = ~cs_n_s & cs_n_dly_q;
  assign cs_rise   = cs_n_s & ~cs_n_dly_q;

  // Fields of a complete frame, and the address while only the header is in
  assign rx_rw    = shreg_q[FRAME_W-1];
  assign rx_addr  = shreg_q[DATA_W +: ADDR_W];
  assign rx_data  = shreg_q[DATA_W-1:0];
  assign hdr_addr = shreg_q[ADDR_W-1:0];

  function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < (ADDR_W+1)'(NUM_REGS);
  endfunction

  function automatic logic [DATA_W-1:0] reg_at(input logic [NUM_REGS*DATA_W-1:0] bank,
                                               input logic [ADDR_W-1:0]          a);
    logic [DATA_W-1:0] val;
    val = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (a == ADDR_W'(k)) val = bank[k*DATA_W +: DATA_W];
    end
    return val;
  endfunction

  always_comb begin
    sclk_dly_d  = sclk_s;
    cs_n_dly_d  = cs_n_s;
    phase_d     = phase_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    overrun_d   = overrun_q;
    out_sh_d    = out_sh_q;
    regs_d      = regs_q;
    wr_stb_d    = 1'b0;
    wr_addr_d   = wr_addr_q;
    frame_err_d = 1'b0;
    cipo_d      = cipo_q;
    cipo_oe_d   = cipo_oe_q;

    // After reset the synchroniser shows its idle pattern until it has
    // flushed. A host already mid-frame then looks like a fresh cs_n fall;
    // frames are only accepted once cs_n has been genuinely seen high, so
    // the tail of an interrupted frame is dropped silently.
    fill_d  = (fill_q == FILL_DONE) ? fill_q : fill_q + FILL_W'(1);
    armed_d = armed_q | ((fill_q == FILL_DONE) & cs_n_s);

    // cs_n edges take priority; any sclk edge in the same cycle is dropped
    if (cs_fall || cs_rise) begin
      if (cs_fall && armed_q) begin
        phase_d   = ADDR;
        bit_cnt_d = '0;
        shreg_d   = '0;
        overrun_d = 1'b0;
        cipo_d    = 1'b0;
        cipo_oe_d = 1'b0;
      end
      if (cs_rise) begin
        phase_d   = IDLE;
        bit_cnt_d = '0;
        cipo_d    = 1'b0;
        cipo_oe_d = 1'b0;
        if (bit_cnt_q != '0) begin
          if (bit_cnt_q != CNT_FRAME || overrun_q) begin
            frame_err_d = 1'b1;
          end else if (rx_rw == RW_BIT_WRITE && addr_in_range(rx_addr)) begin
            for (int k = 0; k < NUM_REGS; k++) begin
              if (rx_addr == ADDR_W'(k)) regs_d[k*DATA_W +: DATA_W] = rx_data;
            end
            wr_stb_d  = 1'b1;
            wr_addr_d = rx_addr;
          end
        end
      end
    end else if (phase_q != IDLE) begin
      if (sclk_rise) begin
        if (bit_cnt_q < CNT_FRAME) begin
          shreg_d   = {shreg_q[FRAME_W-2:0], copi_s};
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_d == CNT_HDR) begin
            phase_d = (shreg_d[ADDR_W] == RW_BIT_WRITE) ? WDATA : RDATA;
          end
        end else begin
          overrun_d = 1'b1;
        end
      end else if (sclk_fall && phase_q == RDATA) begin
        // Snapshot on the first data-phase fall so the whole read is coherent
        if (bit_cnt_q == CNT_HDR) begin
          out_sh_d  = reg_at(regs_q, hdr_addr);
          cipo_d    = out_sh_d[DATA_W-1];
          cipo_oe_d = 1'b1;
        end else if (bit_cnt_q < CNT_FRAME) begin
          out_sh_d = out_sh_q << 1;
          cipo_d   = out_sh_d[DATA_W-1];
        end else begin
          cipo_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge m_clk) begin
    if (!rst_n) begin
      sclk_dly_q  <= 1'b0;
      cs_n_dly_q  <= 1'b1;
      phase_q     <= IDLE;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      overrun_q   <= 1'b0;
      out_sh_q    <= '0;
      fill_q      <= '0;
      armed_q     <= 1'b0;
      regs_q      <= '0;
      wr_stb_q    <= 1'b0;
      wr_addr_q   <= '0;
      frame_err_q <= 1'b0;
      cipo_q      <= 1'b0;
      cipo_oe_q   <= 1'b0;
    end else begin
      sclk_dly_q  <= sclk_dly_d;
      cs_n_dly_q  <= cs_n_dly_d;
      phase_q     <= phase_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      overrun_q   <= overrun_d;
      out_sh_q    <= out_sh_d;
      fill_q      <= fill_d;
      armed_q     <= armed_d;
      regs_q      <= regs_d;
      wr_stb_q    <= wr_stb_d;
      wr_addr_q   <= wr_addr_d;
      frame_err_q <= frame_err_d;
      cipo_q      <= cipo_d;
      cipo_oe_q   <= cipo_oe_d;
    end
  end

  assign regs      = regs_q;
  assign wr_stb    = wr_stb_q;
  assign wr_addr   = wr_addr_q;
  assign frame_err = frame_err_q;
  assign cipo      = cipo_q;
  assign cipo_oe   = cipo_oe_q;

endmodule
